// File: rtl/gups_updater.sv
`timescale 1ns/1ps
// GUPS-style random-access updater: LFSR lanes produce masked word addresses, and each
// selected word is read, incremented or XORed with the random value, and written back.
//
// state  | meaning
// S_IDLE | waiting for start
// S_GEN  | register masked random address
// S_RD   | read request held until rdy
// S_MOD  | compute update word from captured read data
// S_WR   | write request held until rdy
// S_NEXT | count the update, advance LFSRs or finish
// S_DONE | one-cycle completion pulse
module gups_updater #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int LANES  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [CNT_W-1:0]      num_updates,
  input  logic [LANES*16-1:0]   seeds,
  input  logic [ADDR_W-1:0]     range,
  output logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  req,
  output logic                  wr,
  input  logic                  rdy,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      upd_cnt
);

  localparam int          RND_W    = LANES * 16;
  localparam logic [15:0] SEED_DEF = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_RD,
    S_MOD,
    S_WR,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              mode_q;
  logic [CNT_W-1:0]  num_q;
  logic [ADDR_W-1:0] range_q;
  logic [RND_W-1:0]  lfsr;
  logic [RND_W-1:0]  lfsr_adv;
  logic [RND_W-1:0]  lfsr_seed;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] rnd_addr;
  logic [DATA_W-1:0] rnd_data;
  logic [CNT_W-1:0]  cnt_inc;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting toward bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  always_comb begin
    lfsr_adv  = '0;
    lfsr_seed = '0;
    for (int i = 0; i < LANES; i++) begin
      lfsr_adv[16*i +: 16]  = lfsr_step(lfsr[16*i +: 16]);
      lfsr_seed[16*i +: 16] = (seeds[16*i +: 16] == 16'h0000) ? SEED_DEF : seeds[16*i +: 16];
    end
  end

  generate
    if (RND_W >= ADDR_W) begin : g_addr_trunc
      assign rnd_addr = lfsr[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign rnd_addr = {{(ADDR_W-RND_W){1'b0}}, lfsr};
    end
    if (RND_W >= DATA_W) begin : g_data_trunc
      assign rnd_data = lfsr[DATA_W-1:0];
    end else begin : g_data_ext
      assign rnd_data = {{(DATA_W-RND_W){1'b0}}, lfsr};
    end
  endgenerate

  assign cnt_inc = upd_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_updates == '0) ? S_DONE : S_GEN;
        end
      end
      S_GEN:  state_nxt = S_RD;
      S_RD: begin
        if (rdy) state_nxt = S_MOD;
      end
      S_MOD:  state_nxt = S_WR;
      S_WR: begin
        if (rdy) state_nxt = S_NEXT;
      end
      S_NEXT: state_nxt = (cnt_inc == num_q) ? S_DONE : S_GEN;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      num_q   <= '0;
      range_q <= '0;
      lfsr    <= '0;
      rdata   <= '0;
      addr    <= '0;
      dout    <= '0;
      upd_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            num_q   <= num_updates;
            range_q <= range;
            lfsr    <= lfsr_seed;
            upd_cnt <= '0;
          end
        end
        S_GEN: addr <= rnd_addr & range_q;
        S_RD: begin
          if (rdy) rdata <= din;
        end
        S_MOD: dout <= mode_q ? (rdata ^ rnd_data) : (rdata + DATA_W'(1));
        S_NEXT: begin
          upd_cnt <= cnt_inc;
          // lanes only step when another update follows
          if (cnt_inc != num_q) lfsr <= lfsr_adv;
        end
        default: ;
      endcase
    end
  end

  assign req  = (state == S_RD) || (state == S_WR);
  assign wr   = (state == S_WR);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_gups_updater.sv
`timescale 1ns/1ps
// Randomized bench for gups_updater: a memory responder with a reference model of the
// LFSR address stream and the expected read-modify-write results.
module tb_gups_updater;

  logic        clk;
  logic        rst_n;
  logic        start_main, start_spur;
  logic        mode;
  logic [31:0] num_updates;
  logic [63:0] seeds;
  logic [63:0] range_in;
  logic [63:0] addr;
  logic [63:0] din;
  logic [63:0] dout;
  logic        req, wr;
  logic        rdy_resp, rdy_spur;
  logic        busy, done;
  logic [31:0] upd_cnt;

  gups_updater dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_main | start_spur),
    .mode        (mode),
    .num_updates (num_updates),
    .seeds       (seeds),
    .range       (range_in),
    .addr        (addr),
    .din         (din),
    .dout        (dout),
    .req         (req),
    .wr          (wr),
    .rdy         (rdy_resp | rdy_spur),
    .busy        (busy),
    .done        (done),
    .upd_cnt     (upd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [63:0] exp_addr[$];
  logic [63:0] exp_rnd[$];
  logic [63:0] mem[logic [63:0]];
  bit          mode_m;
  logic [63:0] rng_m;
  int          dly_fixed = 1;
  bit          ovr_en = 0;
  logic [63:0] ovr_val = '0;
  bit          phase = 0;
  logic [63:0] pend_addr, pend_exp;
  int          done_total = 0;
  int          req_total = 0;

  function automatic int lfsr_next(input int v);
    int b;
    b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return ((v >> 1) | (b << 15)) & 16'hFFFF;
  endfunction

  task automatic prep_model(input logic [63:0] sd, input logic [63:0] rg, input int n);
    int ln[4];
    logic [63:0] rnd;
    exp_addr.delete();
    exp_rnd.delete();
    for (int i = 0; i < 4; i++) begin
      ln[i] = int'((sd >> (16 * i)) & 64'hFFFF);
      if (ln[i] == 0) ln[i] = 'hACE1;
    end
    for (int k = 0; k < n; k++) begin
      rnd = 64'(ln[0]) + (64'(ln[1]) << 16) + (64'(ln[2]) << 32) + (64'(ln[3]) << 48);
      exp_addr.push_back(rnd & rg);
      exp_rnd.push_back(rnd);
      for (int i = 0; i < 4; i++) ln[i] = lfsr_next(ln[i]);
    end
  endtask

  // memory responder: rdy after a fixed or random 1..6 cycle wait
  initial begin
    rdy_resp = 1'b0;
    din      = '0;
    forever begin
      @(negedge clk);
      if (req === 1'b1) begin
        int d;
        bit ok;
        logic [63:0] ea, er, v;
        d  = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(1, 6));
        ok = 1;
        for (int i = 0; i < d && ok; i++) begin
          @(negedge clk);
          if (req !== 1'b1) ok = 0;
        end
        if (!ok) begin
          phase = 0;
        end else begin
          chk("wr_flag", wr, phase);
          if (!phase) begin
            chk("rd_pending", exp_addr.size() != 0, 1);
            ea = '0;
            er = '0;
            if (exp_addr.size() != 0) begin
              ea = exp_addr.pop_front();
              er = exp_rnd.pop_front();
            end
            chk("rd_addr", addr, ea);
            chk("rd_mask", addr & ~rng_m, 0);
            if (ovr_en) v = ovr_val;
            else if (mem.exists(ea)) v = mem[ea];
            else begin
              v = {$urandom, $urandom};
              mem[ea] = v;
            end
            din       = v;
            pend_addr = ea;
            pend_exp  = mode_m ? (v ^ er) : (v + 64'd1);
            phase     = 1;
          end else begin
            chk("wr_addr", addr, pend_addr);
            chk("wr_data", dout, pend_exp);
            mem[pend_addr] = pend_exp;
            phase = 0;
          end
          rdy_resp = 1'b1;
          @(negedge clk);
          rdy_resp = 1'b0;
          chk("req_drop", req, 0);
        end
      end
    end
  end

  // spurious rdy outside RD/WR and spurious start while busy
  initial begin
    rdy_spur   = 1'b0;
    start_spur = 1'b0;
    forever begin
      @(negedge clk);
      rdy_spur   = busy && !req && ($urandom_range(0, 3) == 0);
      start_spur = busy && ($urandom_range(0, 7) == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_total++;
      if (req === 1'b1) req_total++;
    end
  end

  task automatic scramble_inputs();
    mode        = $urandom_range(0, 1) == 1;
    num_updates = $urandom_range(1, 5);
    seeds       = {$urandom, $urandom};
    range_in    = {$urandom, $urandom};
  endtask

  task automatic run(input string tag, input bit m, input int n, input logic [63:0] sd,
                     input logic [63:0] rg, input int dly);
    int cyc, budget, d0, r0;
    mode_m    = m;
    rng_m     = rg;
    dly_fixed = dly;
    prep_model(sd, rg, n);
    budget = n * 20 + 50;
    d0 = done_total;
    r0 = req_total;
    @(negedge clk);
    start_main  = 1'b1;
    mode        = m;
    num_updates = n;
    seeds       = sd;
    range_in    = rg;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_main = 1'b0;
        scramble_inputs();
      end
    end while (!done && cyc < budget);
    chk({tag, "_done_seen"}, done, 1);
    if (dly >= 0) chk({tag, "_latency"}, cyc, n * (5 + 2 * dly) + 1);
    chk({tag, "_upd_cnt"}, upd_cnt, n);
    repeat (2) @(negedge clk);
    chk({tag, "_done_once"}, done_total - d0, 1);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_cnt_hold"}, upd_cnt, n);
    chk({tag, "_all_reads"}, exp_addr.size(), 0);
    if (n == 0) chk({tag, "_no_req"}, req_total - r0, 0);
  endtask

  initial begin
    int cyc;
    rst_n       = 1'b0;
    start_main  = 1'b0;
    mode        = 1'b0;
    num_updates = '0;
    seeds       = '0;
    range_in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_req",  req, 0);
    chk("rst_wr",   wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_cnt",  upd_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);

    run("single", 0, 1, {4{16'h0001}}, 64'h1FFF, 2);
    run("zero_n", 0, 0, {$urandom, $urandom}, 64'hFFFF, 1);
    run("zseed", 0, 20, {16'h0000, 16'hACE1, 16'h0000, 16'h1234}, 64'hFFFF, -1);
    run("zseed_all", 1, 10, 64'h0, 64'hFFFF_FFFF, 0);

    ovr_en  = 1;
    ovr_val = '1;
    run("xor_ones", 1, 8, {$urandom, $urandom}, '1, -1);
    run("inc_wrap", 0, 4, {$urandom, $urandom}, 64'h3FF, -1);
    ovr_en  = 0;

    run("long_inc", 0, 1024, {$urandom, $urandom}, 64'hFF, -1);
    run("long_xor", 1, 300, {$urandom, $urandom}, {$urandom, $urandom}, -1);

    // reset while a write is outstanding on a later update
    mode_m    = 0;
    rng_m     = 64'hFFF;
    dly_fixed = 3;
    prep_model(64'h1111_2222_3333_4444, 64'hFFF, 10);
    @(negedge clk);
    start_main  = 1'b1;
    mode        = 1'b0;
    num_updates = 10;
    seeds       = 64'h1111_2222_3333_4444;
    range_in    = 64'hFFF;
    @(negedge clk);
    start_main = 1'b0;
    cyc = 0;
    while (!(req && wr && upd_cnt >= 2) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach_wr", req && wr && upd_cnt >= 2, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",  req, 0);
    chk("arst_wr",   wr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", addr, 0);
    chk("arst_dout", dout, 0);
    chk("arst_cnt",  upd_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_stay_idle", busy, 0);
    exp_addr.delete();
    exp_rnd.delete();
    run("after_rst", 0, 5, 64'h0BAD_F00D_1357_2468, 64'hFFFF, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
